// File: rtl/ysyx_23060025_arbiter_if.sv
// Bus bundle between the IFU/LSU requesters, the arbiter and the downstream xbar.
// The master modport is the arbiter's view; the slave modport is the surrounding environment.
interface ysyx_23060025_arbiter_if #(
   parameter int ADDR_LEN = 32,
   parameter int DATA_LEN = 32
);
   logic [ADDR_LEN-1:0] ifu_ar_addr_i;
   logic                ifu_ar_valid_i, ifu_ar_ready_o;
   logic [DATA_LEN-1:0] ifu_r_data_o;
   logic [1:0]          ifu_r_resp_o;
   logic                ifu_r_valid_o, ifu_r_last_o, ifu_r_ready_i;

   logic [ADDR_LEN-1:0] lsu_ar_addr_i;
   logic [7:0]          lsu_ar_len_i;
   logic [2:0]          lsu_ar_size_i;
   logic                lsu_ar_valid_i, lsu_ar_ready_o;
   logic [DATA_LEN-1:0] lsu_r_data_o;
   logic [1:0]          lsu_r_resp_o;
   logic                lsu_r_valid_o, lsu_r_last_o, lsu_r_ready_i;
   logic [ADDR_LEN-1:0] lsu_aw_addr_i;
   logic [7:0]          lsu_aw_len_i;
   logic [2:0]          lsu_aw_size_i;
   logic                lsu_aw_valid_i, lsu_aw_ready_o;
   logic [DATA_LEN-1:0] lsu_w_data_i;
   logic [3:0]          lsu_w_strb_i;
   logic                lsu_w_last_i, lsu_w_valid_i, lsu_w_ready_o;
   logic [1:0]          lsu_b_resp_o;
   logic                lsu_b_valid_o, lsu_b_ready_i;

   logic [ADDR_LEN-1:0] m_ar_addr_o;
   logic [3:0]          m_ar_id_o;
   logic [7:0]          m_ar_len_o;
   logic [2:0]          m_ar_size_o;
   logic [1:0]          m_ar_burst_o;
   logic                m_ar_valid_o, m_ar_ready_i;
   logic [DATA_LEN-1:0] m_r_data_i;
   logic [1:0]          m_r_resp_i;
   logic                m_r_last_i;
   logic [3:0]          m_r_id_i;
   logic                m_r_valid_i, m_r_ready_o;
   logic [ADDR_LEN-1:0] m_aw_addr_o;
   logic [3:0]          m_aw_id_o;
   logic [7:0]          m_aw_len_o;
   logic [2:0]          m_aw_size_o;
   logic [1:0]          m_aw_burst_o;
   logic                m_aw_valid_o, m_aw_ready_i;
   logic [DATA_LEN-1:0] m_w_data_o;
   logic [3:0]          m_w_strb_o;
   logic                m_w_last_o, m_w_valid_o, m_w_ready_i;
   logic [1:0]          m_b_resp_i;
   logic [3:0]          m_b_id_i;
   logic                m_b_valid_i, m_b_ready_o;

   logic [1:0]          grant_o;

   modport master (
      input  ifu_ar_addr_i, ifu_ar_valid_i, ifu_r_ready_i,
      output ifu_ar_ready_o, ifu_r_data_o, ifu_r_resp_o, ifu_r_valid_o, ifu_r_last_o,
      input  lsu_ar_addr_i, lsu_ar_len_i, lsu_ar_size_i, lsu_ar_valid_i, lsu_r_ready_i,
      output lsu_ar_ready_o, lsu_r_data_o, lsu_r_resp_o, lsu_r_valid_o, lsu_r_last_o,
      input  lsu_aw_addr_i, lsu_aw_len_i, lsu_aw_size_i, lsu_aw_valid_i,
      input  lsu_w_data_i, lsu_w_strb_i, lsu_w_last_i, lsu_w_valid_i, lsu_b_ready_i,
      output lsu_aw_ready_o, lsu_w_ready_o, lsu_b_resp_o, lsu_b_valid_o,
      output m_ar_addr_o, m_ar_id_o, m_ar_len_o, m_ar_size_o, m_ar_burst_o, m_ar_valid_o,
      input  m_ar_ready_i, m_r_data_i, m_r_resp_i, m_r_last_i, m_r_id_i, m_r_valid_i,
      output m_r_ready_o,
      output m_aw_addr_o, m_aw_id_o, m_aw_len_o, m_aw_size_o, m_aw_burst_o, m_aw_valid_o,
      input  m_aw_ready_i,
      output m_w_data_o, m_w_strb_o, m_w_last_o, m_w_valid_o,
      input  m_w_ready_i, m_b_resp_i, m_b_id_i, m_b_valid_i,
      output m_b_ready_o, grant_o
   );

   modport slave (
      output ifu_ar_addr_i, ifu_ar_valid_i, ifu_r_ready_i,
      input  ifu_ar_ready_o, ifu_r_data_o, ifu_r_resp_o, ifu_r_valid_o, ifu_r_last_o,
      output lsu_ar_addr_i, lsu_ar_len_i, lsu_ar_size_i, lsu_ar_valid_i, lsu_r_ready_i,
      input  lsu_ar_ready_o, lsu_r_data_o, lsu_r_resp_o, lsu_r_valid_o, lsu_r_last_o,
      output lsu_aw_addr_i, lsu_aw_len_i, lsu_aw_size_i, lsu_aw_valid_i,
      output lsu_w_data_i, lsu_w_strb_i, lsu_w_last_i, lsu_w_valid_i, lsu_b_ready_i,
      input  lsu_aw_ready_o, lsu_w_ready_o, lsu_b_resp_o, lsu_b_valid_o,
      input  m_ar_addr_o, m_ar_id_o, m_ar_len_o, m_ar_size_o, m_ar_burst_o, m_ar_valid_o,
      output m_ar_ready_i, m_r_data_i, m_r_resp_i, m_r_last_i, m_r_id_i, m_r_valid_i,
      input  m_r_ready_o,
      input  m_aw_addr_o, m_aw_id_o, m_aw_len_o, m_aw_size_o, m_aw_burst_o, m_aw_valid_o,
      output m_aw_ready_i,
      input  m_w_data_o, m_w_strb_o, m_w_last_o, m_w_valid_o,
      output m_w_ready_i, m_b_resp_i, m_b_id_i, m_b_valid_i,
      input  m_b_ready_o, grant_o
   );
endinterface

// File: rtl/ysyx_23060025_arbiter.sv
// Two-requester (IFU, LSU) AXI arbiter with one transaction outstanding downstream.
// Round-robin between IFU and LSU; LSU write beats LSU read; grant is registered.
module ysyx_23060025_arbiter (
   input logic                     clock,
   input logic                     reset,
   ysyx_23060025_arbiter_if.master bus
);
   typedef enum logic [1:0] {IDLE, IFU_RD, LSU_RD, LSU_WR} state_t;

   localparam logic [3:0] IFU_ID      = 4'd0;
   localparam logic [3:0] LSU_ID      = 4'd1;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   state_t state, state_nxt;
   logic   last_lsu;
   logic   ar_done, aw_done, w_done;
   logic   ifu_req, lsu_req, pick_lsu;

   assign ifu_req = bus.ifu_ar_valid_i;
   assign lsu_req = bus.lsu_aw_valid_i | bus.lsu_ar_valid_i;

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         last_lsu <= 1'b0;
         ar_done  <= 1'b0;
         aw_done  <= 1'b0;
         w_done   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && state_nxt != IDLE) last_lsu <= (state_nxt != IFU_RD);
         if (state_nxt == IDLE) begin
            ar_done <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
         end else begin
            if (bus.m_ar_valid_o && bus.m_ar_ready_i) ar_done <= 1'b1;
            if (bus.m_aw_valid_o && bus.m_aw_ready_i) aw_done <= 1'b1;
            if (bus.m_w_valid_o && bus.m_w_ready_i && bus.m_w_last_o) w_done <= 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt          = state;
      pick_lsu           = 1'b0;
      bus.grant_o        = 2'b00;
      bus.ifu_ar_ready_o = 1'b0;
      bus.ifu_r_data_o   = '0;
      bus.ifu_r_resp_o   = 2'b00;
      bus.ifu_r_valid_o  = 1'b0;
      bus.ifu_r_last_o   = 1'b0;
      bus.lsu_ar_ready_o = 1'b0;
      bus.lsu_r_data_o   = '0;
      bus.lsu_r_resp_o   = 2'b00;
      bus.lsu_r_valid_o  = 1'b0;
      bus.lsu_r_last_o   = 1'b0;
      bus.lsu_aw_ready_o = 1'b0;
      bus.lsu_w_ready_o  = 1'b0;
      bus.lsu_b_resp_o   = 2'b00;
      bus.lsu_b_valid_o  = 1'b0;
      bus.m_ar_addr_o    = '0;
      bus.m_ar_id_o      = 4'd0;
      bus.m_ar_len_o     = 8'd0;
      bus.m_ar_size_o    = 3'd0;
      bus.m_ar_burst_o   = 2'b00;
      bus.m_ar_valid_o   = 1'b0;
      bus.m_r_ready_o    = 1'b0;
      bus.m_aw_addr_o    = '0;
      bus.m_aw_id_o      = 4'd0;
      bus.m_aw_len_o     = 8'd0;
      bus.m_aw_size_o    = 3'd0;
      bus.m_aw_burst_o   = 2'b00;
      bus.m_aw_valid_o   = 1'b0;
      bus.m_w_data_o     = '0;
      bus.m_w_strb_o     = 4'd0;
      bus.m_w_last_o     = 1'b0;
      bus.m_w_valid_o    = 1'b0;
      bus.m_b_ready_o    = 1'b0;

      case (state)
         IDLE: begin
            // LSU wins unless IFU also asks and LSU held the last grant
            pick_lsu = lsu_req && (!ifu_req || !last_lsu);
            if (pick_lsu)     state_nxt = bus.lsu_aw_valid_i ? LSU_WR : LSU_RD;
            else if (ifu_req) state_nxt = IFU_RD;
         end
         IFU_RD: begin
            bus.grant_o        = 2'b01;
            bus.m_ar_addr_o    = bus.ifu_ar_addr_i;
            bus.m_ar_id_o      = IFU_ID;
            bus.m_ar_len_o     = 8'd0;
            bus.m_ar_size_o    = 3'b010;
            bus.m_ar_burst_o   = BURST_INCR;
            bus.m_ar_valid_o   = !ar_done;
            bus.ifu_ar_ready_o = bus.m_ar_ready_i && !ar_done;
            bus.ifu_r_data_o   = bus.m_r_data_i;
            bus.ifu_r_resp_o   = (bus.m_r_id_i == IFU_ID) ? bus.m_r_resp_i : RESP_SLVERR;
            bus.ifu_r_valid_o  = bus.m_r_valid_i;
            bus.ifu_r_last_o   = bus.m_r_last_i;
            bus.m_r_ready_o    = bus.ifu_r_ready_i;
            if (bus.m_r_valid_i && bus.ifu_r_ready_i && bus.m_r_last_i) state_nxt = IDLE;
         end
         LSU_RD: begin
            bus.grant_o        = 2'b10;
            bus.m_ar_addr_o    = bus.lsu_ar_addr_i;
            bus.m_ar_id_o      = LSU_ID;
            bus.m_ar_len_o     = bus.lsu_ar_len_i;
            bus.m_ar_size_o    = bus.lsu_ar_size_i;
            bus.m_ar_burst_o   = BURST_INCR;
            bus.m_ar_valid_o   = !ar_done;
            bus.lsu_ar_ready_o = bus.m_ar_ready_i && !ar_done;
            bus.lsu_r_data_o   = bus.m_r_data_i;
            bus.lsu_r_resp_o   = (bus.m_r_id_i == LSU_ID) ? bus.m_r_resp_i : RESP_SLVERR;
            bus.lsu_r_valid_o  = bus.m_r_valid_i;
            bus.lsu_r_last_o   = bus.m_r_last_i;
            bus.m_r_ready_o    = bus.lsu_r_ready_i;
            if (bus.m_r_valid_i && bus.lsu_r_ready_i && bus.m_r_last_i) state_nxt = IDLE;
         end
         LSU_WR: begin
            // AW and W run independently; W may complete before AW
            bus.grant_o        = 2'b10;
            bus.m_aw_addr_o    = bus.lsu_aw_addr_i;
            bus.m_aw_id_o      = LSU_ID;
            bus.m_aw_len_o     = bus.lsu_aw_len_i;
            bus.m_aw_size_o    = bus.lsu_aw_size_i;
            bus.m_aw_burst_o   = BURST_INCR;
            bus.m_aw_valid_o   = !aw_done;
            bus.lsu_aw_ready_o = bus.m_aw_ready_i && !aw_done;
            bus.m_w_data_o     = bus.lsu_w_data_i;
            bus.m_w_strb_o     = bus.lsu_w_strb_i;
            bus.m_w_last_o     = bus.lsu_w_last_i;
            bus.m_w_valid_o    = bus.lsu_w_valid_i && !w_done;
            bus.lsu_w_ready_o  = bus.m_w_ready_i && !w_done;
            bus.lsu_b_resp_o   = (bus.m_b_id_i == LSU_ID) ? bus.m_b_resp_i : RESP_SLVERR;
            bus.lsu_b_valid_o  = bus.m_b_valid_i;
            bus.m_b_ready_o    = bus.lsu_b_ready_i;
            if (bus.m_b_valid_i && bus.lsu_b_ready_i) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end
endmodule

// File: tb/tb_ysyx_23060025_arbiter.sv
// Randomized bench for the IFU/LSU arbiter: the bench plays IFU, LSU and downstream slave,
// and predicts grant order from the round-robin / write-first rules with a pending-request queue.
module tb_ysyx_23060025_arbiter;
   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   ysyx_23060025_arbiter_if bus ();
   ysyx_23060025_arbiter dut (.clock(clock), .reset(reset), .bus(bus));

   int checks = 0;
   int errors = 0;

   // requester side
   bit          ifu_v, lr_v, lw_aw_v, lw_w_v;
   logic [31:0] ifu_addr, lr_addr, lw_addr, lw_data;
   logic [7:0]  lr_len, lw_len;
   logic [2:0]  lr_size, lw_size;
   logic [3:0]  lw_strb;
   bit          ifu_rdy, lsu_rdy, b_rdy;
   // downstream slave side
   int          owner;          // 0 none, 1 IFU read, 2 LSU read, 3 LSU write
   bit          ar_seen, aw_seen, w_seen, b_pend, released;
   int          r_left;
   logic [31:0] rdata;
   logic [1:0]  rresp, bresp;
   logic [3:0]  rid, bid;
   // reference model
   bit          last_lsu_m;
   int          expq[$];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [11:0] quiet_vec();
      return {bus.m_ar_valid_o, bus.m_aw_valid_o, bus.m_w_valid_o, bus.m_r_ready_o,
              bus.m_b_ready_o, bus.ifu_ar_ready_o, bus.lsu_ar_ready_o, bus.lsu_aw_ready_o,
              bus.lsu_w_ready_o, bus.ifu_r_valid_o, bus.lsu_r_valid_o, bus.lsu_b_valid_o};
   endfunction

   function automatic logic [3:0] exp_id();
      return (owner == 1) ? 4'd0 : 4'd1;
   endfunction

   task automatic new_rbeat();
      rdata = $urandom;
      rresp = 2'($urandom_range(0, 3));
      rid   = ($urandom_range(0, 5) == 0) ? 4'd3 : exp_id();
   endtask

   task automatic drive();
      bus.ifu_ar_valid_i = ifu_v;   bus.ifu_ar_addr_i = ifu_addr;
      bus.lsu_ar_valid_i = lr_v;    bus.lsu_ar_addr_i = lr_addr;
      bus.lsu_ar_len_i   = lr_len;  bus.lsu_ar_size_i = lr_size;
      bus.lsu_aw_valid_i = lw_aw_v; bus.lsu_aw_addr_i = lw_addr;
      bus.lsu_aw_len_i   = lw_len;  bus.lsu_aw_size_i = lw_size;
      bus.lsu_w_valid_i  = lw_w_v;  bus.lsu_w_data_i  = lw_data;
      bus.lsu_w_strb_i   = lw_strb; bus.lsu_w_last_i  = 1'b1;
      ifu_rdy = ($urandom_range(0, 3) != 0);
      lsu_rdy = ($urandom_range(0, 3) != 0);
      b_rdy   = ($urandom_range(0, 3) != 0);
      bus.ifu_r_ready_i = ifu_rdy;
      bus.lsu_r_ready_i = lsu_rdy;
      bus.lsu_b_ready_i = b_rdy;
      bus.m_ar_ready_i  = 1'($urandom_range(0, 1));
      bus.m_aw_ready_i  = 1'($urandom_range(0, 1));
      bus.m_w_ready_i   = 1'($urandom_range(0, 1));
      bus.m_r_valid_i   = (r_left > 0);
      bus.m_r_data_i    = rdata;
      bus.m_r_resp_i    = rresp;
      bus.m_r_id_i      = rid;
      bus.m_r_last_i    = (r_left == 1);
      bus.m_b_valid_i   = b_pend;
      bus.m_b_resp_i    = bresp;
      bus.m_b_id_i      = bid;
   endtask

   task automatic release_owner();
      owner = 0; released = 1'b1; r_left = 0; b_pend = 1'b0;
   endtask

   task automatic step();
      logic [1:0]  g;
      logic [1:0]  xresp;
      bit          rdy;
      @(negedge clock);
      drive();
      #1;
      g = bus.grant_o;
      if (owner == 0) begin
         if (released) chk("idle_gap", g, 2'b00);
         released = 1'b0;
         if (g == 2'b00) chk("idle_quiet", quiet_vec(), 12'd0);
         else if (expq.size() == 0) chk("spurious_grant", g, 2'b00);
         else begin
            owner = expq.pop_front();
            ar_seen = 1'b0; aw_seen = 1'b0; w_seen = 1'b0; r_left = 0; b_pend = 1'b0;
            chk("grant", g, (owner == 1) ? 2'b01 : 2'b10);
            chk("first_valid", {bus.m_ar_valid_o, bus.m_aw_valid_o}, (owner == 3) ? 2'b01 : 2'b10);
         end
      end
      if (owner == 1 || owner == 2) begin
         chk("grant_hold", g, (owner == 1) ? 2'b01 : 2'b10);
         chk("rd_no_wr", {bus.m_aw_valid_o, bus.m_w_valid_o, bus.lsu_aw_ready_o, bus.lsu_w_ready_o,
                          bus.lsu_b_valid_o, bus.m_b_ready_o}, 6'd0);
         chk("other_ar_rdy", (owner == 1) ? bus.lsu_ar_ready_o : bus.ifu_ar_ready_o, 1'b0);
         if (bus.m_r_valid_i) begin
            rdy   = (owner == 1) ? ifu_rdy : lsu_rdy;
            xresp = (rid == exp_id()) ? rresp : 2'b10;
            if (owner == 1) begin
               chk("r_valid", bus.ifu_r_valid_o, 1'b1);
               chk("r_data", bus.ifu_r_data_o, rdata);
               chk("r_resp", bus.ifu_r_resp_o, xresp);
               chk("r_last", bus.ifu_r_last_o, (r_left == 1));
               chk("r_other", bus.lsu_r_valid_o, 1'b0);
            end else begin
               chk("r_valid", bus.lsu_r_valid_o, 1'b1);
               chk("r_data", bus.lsu_r_data_o, rdata);
               chk("r_resp", bus.lsu_r_resp_o, xresp);
               chk("r_last", bus.lsu_r_last_o, (r_left == 1));
               chk("r_other", bus.ifu_r_valid_o, 1'b0);
            end
            chk("m_r_ready", bus.m_r_ready_o, rdy);
            if (rdy) begin
               r_left--;
               if (r_left == 0) release_owner();
               else new_rbeat();
            end
         end else if (ar_seen) begin
            chk("ar_done_low", bus.m_ar_valid_o, 1'b0);
         end else if (bus.m_ar_valid_o && bus.m_ar_ready_i) begin
            chk("ar_addr", bus.m_ar_addr_o, (owner == 1) ? ifu_addr : lr_addr);
            chk("ar_id", bus.m_ar_id_o, exp_id());
            chk("ar_len", bus.m_ar_len_o, (owner == 1) ? 8'd0 : lr_len);
            chk("ar_size", bus.m_ar_size_o, (owner == 1) ? 3'd2 : lr_size);
            chk("ar_burst", bus.m_ar_burst_o, 2'b01);
            chk("ar_rdy_req", (owner == 1) ? bus.ifu_ar_ready_o : bus.lsu_ar_ready_o, 1'b1);
            ar_seen = 1'b1;
            if (owner == 1) ifu_v = 1'b0; else lr_v = 1'b0;
            r_left = (owner == 1) ? 1 : int'(lr_len) + 1;
            new_rbeat();
         end
      end else if (owner == 3) begin
         chk("grant_hold", g, 2'b10);
         chk("wr_no_rd", {bus.m_ar_valid_o, bus.ifu_ar_ready_o, bus.lsu_ar_ready_o, bus.m_r_ready_o,
                          bus.ifu_r_valid_o, bus.lsu_r_valid_o}, 6'd0);
         if (aw_seen) chk("aw_done_low", bus.m_aw_valid_o, 1'b0);
         else if (bus.m_aw_valid_o && bus.m_aw_ready_i) begin
            chk("aw_addr", bus.m_aw_addr_o, lw_addr);
            chk("aw_id", bus.m_aw_id_o, 4'd1);
            chk("aw_len", bus.m_aw_len_o, lw_len);
            chk("aw_size", bus.m_aw_size_o, lw_size);
            chk("aw_burst", bus.m_aw_burst_o, 2'b01);
            chk("aw_rdy_req", bus.lsu_aw_ready_o, 1'b1);
            aw_seen = 1'b1; lw_aw_v = 1'b0;
         end
         if (w_seen) chk("w_done_low", bus.m_w_valid_o, 1'b0);
         else if (bus.m_w_valid_o && bus.m_w_ready_i) begin
            chk("w_data", bus.m_w_data_o, lw_data);
            chk("w_strb", bus.m_w_strb_o, lw_strb);
            chk("w_last", bus.m_w_last_o, 1'b1);
            chk("w_rdy_req", bus.lsu_w_ready_o, 1'b1);
            w_seen = 1'b1; lw_w_v = 1'b0;
         end
         if (bus.m_b_valid_i) begin
            chk("b_valid", bus.lsu_b_valid_o, 1'b1);
            chk("b_resp", bus.lsu_b_resp_o, (bid == 4'd1) ? bresp : 2'b10);
            chk("m_b_ready", bus.m_b_ready_o, b_rdy);
            if (b_rdy) release_owner();
         end else if (aw_seen && w_seen && !b_pend) begin
            b_pend = 1'b1;
            bresp  = 2'($urandom_range(0, 3));
            bid    = ($urandom_range(0, 4) == 0) ? 4'd3 : 4'd1;
         end
      end
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1;
      ifu_v = 1'b0; lr_v = 1'b0; lw_aw_v = 1'b0; lw_w_v = 1'b0;
      owner = 0; r_left = 0; b_pend = 1'b0; released = 1'b0;
      expq.delete();
      last_lsu_m = 1'b0;
      drive();
      @(negedge clock);
      reset = 1'b0;
      #1;
      chk("rst_grant", bus.grant_o, 2'b00);
      chk("rst_quiet", quiet_vec(), 12'd0);
   endtask

   // Requests issued together; model resolves order from round-robin and write-first rules.
   task automatic scenario(input bit ri, input bit rl, input bit rw, input logic [31:0] iaddr);
      bit p_i, p_r, p_w;
      int n;
      ifu_addr = iaddr;
      lr_addr  = $urandom & 32'hffff_fffc;
      lr_len   = 8'($urandom_range(0, 3));
      lr_size  = 3'($urandom_range(0, 2));
      lw_addr  = $urandom & 32'hffff_fffc;
      lw_len   = 8'($urandom_range(0, 3));
      lw_size  = 3'($urandom_range(0, 2));
      lw_data  = $urandom;
      lw_strb  = 4'($urandom_range(1, 15));
      ifu_v = ri; lr_v = rl; lw_aw_v = rw; lw_w_v = rw;
      p_i = ri; p_r = rl; p_w = rw;
      while (p_i || p_r || p_w) begin
         if (p_i && (!(p_r || p_w) || last_lsu_m)) begin
            expq.push_back(1); p_i = 1'b0; last_lsu_m = 1'b0;
         end else if (p_w) begin
            expq.push_back(3); p_w = 1'b0; last_lsu_m = 1'b1;
         end else begin
            expq.push_back(2); p_r = 1'b0; last_lsu_m = 1'b1;
         end
      end
      n = 0;
      while ((expq.size() > 0 || owner != 0) && n < 300) begin
         step();
         n++;
      end
      if (n >= 300) begin
         chk("timeout", 1'b0, 1'b1);
         do_reset();
      end
      step();
   endtask

   initial begin
      int  n;
      bit  ri, rl, rw;
      ifu_addr = '0; lr_addr = '0; lw_addr = '0; lw_data = '0;
      lr_len = '0; lw_len = '0; lr_size = '0; lw_size = '0; lw_strb = '0;
      rdata = '0; rresp = '0; rid = '0; bresp = '0; bid = '0;
      do_reset();
      scenario(1'b1, 1'b0, 1'b0, 32'h8000_0000);
      do_reset();
      scenario(1'b1, 1'b1, 1'b0, $urandom & 32'hffff_fffc);
      scenario(1'b1, 1'b1, 1'b0, $urandom & 32'hffff_fffc);
      scenario(1'b1, 1'b0, 1'b1, $urandom & 32'hffff_fffc);
      for (int i = 0; i < 80; i++) begin
         do begin
            ri = 1'($urandom_range(0, 1));
            rl = 1'($urandom_range(0, 1));
            rw = 1'($urandom_range(0, 1));
         end while (!(ri || rl || rw));
         scenario(ri, rl, rw, $urandom & 32'hffff_fffc);
      end
      // reset while an LSU read waits for its data
      lr_addr = $urandom & 32'hffff_fffc; lr_len = 8'd0; lr_size = 3'd2; lr_v = 1'b1;
      expq.push_back(2); last_lsu_m = 1'b1;
      n = 0;
      while (!(owner == 2 && ar_seen) && n < 50) begin
         step();
         n++;
      end
      chk("rst_setup", (owner == 2 && ar_seen), 1'b1);
      do_reset();
      @(negedge clock);
      bus.m_r_valid_i = 1'b1; bus.m_r_last_i = 1'b1; bus.m_r_id_i = 4'd1; bus.lsu_r_ready_i = 1'b1;
      #1;
      chk("late_r_fwd", bus.lsu_r_valid_o, 1'b0);
      chk("late_r_ready", bus.m_r_ready_o, 1'b0);
      chk("late_r_grant", bus.grant_o, 2'b00);
      scenario(1'b1, 1'b1, 1'b0, $urandom & 32'hffff_fffc);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=running exp=finished");
      $fatal(1, "watchdog");
   end
endmodule
